oclib_uart_rx: RTL and testbench

- Synthesizable UART receiver, 8N1 framing, LSB first, idle-high line.
- Sits in the design on the serial pin driven by the simulation UART model or an external host.
- Oversamples the line using the system clock and samples each bit at its centre.
- Buffers received bytes in a small FIFO and presents them on a valid/ready byte interface.

---
 rtl/oclib_uart_rx.sv | 260 ++++++++++++++++++++++++++
 tb/tb_oclib_uart_rx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_uart_rx.sv
// oclib_uart_rx -- UART receiver with a small byte FIFO.
//
// Receives 8N1 frames (LSB first, idle-high line). The line is
// oversampled with the system clock and each bit is sampled at its
// centre. Received bytes go into a FifoDepth-entry FIFO that is
// presented on a valid/ready byte interface.
//
// Optional feature: define OCLIB_UART_RX_PARITY_EN to receive 8E1
// frames. A PARITY state is then generated, and a frame with bad
// parity raises parityError and is never pushed. Without the macro,
// parityError is tied to 0.
//
// Parameters:
//   ClockHz    clock frequency in Hz
//   Baud       line rate in bits per second
//   FifoDepth  received-byte buffer depth (power of 2, >= 2)
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   rx           serial line (asynchronous to clock)
//   rxData       byte at the FIFO head (registered)
//   rxValid      FIFO non-empty (registered)
//   rxReady      consumer takes rxData when rxValid && rxReady
//   frameError   1-cycle pulse: stop bit sampled low
//   overflow     1-cycle pulse: completed byte dropped, FIFO full
//   parityError  1-cycle pulse: parity mismatch (parity build only)
module oclib_uart_rx #(
  parameter int ClockHz   = 100000000,
  parameter int Baud      = 115200,
  parameter int FifoDepth = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  output logic       frameError,
  output logic       overflow,
  output logic       parityError
);

  localparam int CyclesPerBit = (ClockHz + Baud / 2) / Baud;
  localparam int HalfBit      = CyclesPerBit / 2;
  localparam int CntW         = $clog2(CyclesPerBit);
  localparam int AddrW        = $clog2(FifoDepth);
  localparam logic [CntW-1:0]  HalfLoad  = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0]  BitLoad   = CntW'(CyclesPerBit - 1);
  localparam logic [AddrW:0]   FullCount = (AddrW + 1)'(FifoDepth);

  generate
    if (CyclesPerBit < 8) begin : gBadRate
      $error("oclib_uart_rx: CyclesPerBit must be at least 8");
    end
    if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : gBadDepth
      $error("oclib_uart_rx: FifoDepth must be a power of 2, at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef OCLIB_UART_RX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4,
    StBreak  = 3'd5
  } stateT;

  // ---------------------------------------------------------------
  // Synchronizer plus history flop. All reset to 1 so a line held
  // low through reset only shows up as an edge once the 0 has passed
  // through the synchronizer.
  // ---------------------------------------------------------------
  logic syncA, syncB, rxHist;
  logic fallingEdge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      syncA  <= 1'b1;
      syncB  <= 1'b1;
      rxHist <= 1'b1;
    end else begin
      syncA  <= rx;
      syncB  <= syncA;
      rxHist <= syncB;
    end
  end

  assign fallingEdge = rxHist & ~syncB;

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  stateT           stateReg, stateNext;
  logic [CntW-1:0] bitCnt;
  logic [2:0]      bitIndex;
  logic [7:0]      shiftReg;
  logic            expiry;
  logic            parityBad;

  logic loadHalf, loadBit, startOk, shiftEn, pushReq, frameErrSet;
`ifdef OCLIB_UART_RX_PARITY_EN
  logic parityCheck, parityErrSet;
`endif

  assign expiry = (bitCnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stateReg <= StIdle;
    else       stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      StIdle:   if (fallingEdge) stateNext = StStart;
      StStart:  if (expiry) stateNext = syncB ? StIdle : StData;
      StData:
        if (expiry && (bitIndex == 3'd7)) begin
`ifdef OCLIB_UART_RX_PARITY_EN
          stateNext = StParity;
`else
          stateNext = StStop;
`endif
        end
`ifdef OCLIB_UART_RX_PARITY_EN
      StParity: if (expiry) stateNext = StStop;
`endif
      StStop:   if (expiry) stateNext = syncB ? StIdle : StBreak;
      StBreak:  if (syncB) stateNext = StIdle;
      default:  stateNext = StIdle;
    endcase
  end

  always_comb begin
    loadHalf     = 1'b0;
    loadBit      = 1'b0;
    startOk      = 1'b0;
    shiftEn      = 1'b0;
    pushReq      = 1'b0;
    frameErrSet  = 1'b0;
`ifdef OCLIB_UART_RX_PARITY_EN
    parityCheck  = 1'b0;
    parityErrSet = 1'b0;
`endif
    case (stateReg)
      StIdle:  loadHalf = fallingEdge;
      StStart: begin
        // A high sample at mid-start means the edge was a glitch.
        startOk = expiry & ~syncB;
        loadBit = expiry & ~syncB;
      end
      StData: begin
        shiftEn = expiry;
        loadBit = expiry;
      end
`ifdef OCLIB_UART_RX_PARITY_EN
      StParity: begin
        parityCheck = expiry;
        loadBit     = expiry;
      end
`endif
      StStop: begin
        pushReq     = expiry & syncB & ~parityBad;
        frameErrSet = expiry & ~syncB;
`ifdef OCLIB_UART_RX_PARITY_EN
        parityErrSet = expiry & syncB & parityBad;
`endif
      end
      default: ;
    endcase
  end

  // Bit timer, bit index and shift register. The timer parks at 0
  // outside an active bit, so expiry in IDLE/BREAK is harmless.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitCnt   <= '0;
      bitIndex <= '0;
      shiftReg <= '0;
    end else begin
      if (loadHalf)     bitCnt <= HalfLoad;
      else if (loadBit) bitCnt <= BitLoad;
      else if (!expiry) bitCnt <= bitCnt - CntW'(1);

      if (startOk)      bitIndex <= '0;
      else if (shiftEn) bitIndex <= bitIndex + 3'd1;

      if (shiftEn) shiftReg[bitIndex] <= syncB;
    end
  end

`ifdef OCLIB_UART_RX_PARITY_EN
  // Even parity: data plus parity bit must XOR to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parityBad   <= 1'b0;
      parityError <= 1'b0;
    end else begin
      if (startOk)          parityBad <= 1'b0;
      else if (parityCheck) parityBad <= ^{shiftReg, syncB};
      parityError <= parityErrSet;
    end
  end
`else
  assign parityBad   = 1'b0;
  assign parityError = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Byte FIFO. Storage has no reset so it can map onto RAM; the head
  // is read combinationally and registered into rxData.
  // ---------------------------------------------------------------
  logic [7:0]       fifoMem [FifoDepth];
  logic [AddrW-1:0] wrPtr, rdPtr, rdPtrNext;
  logic [AddrW:0]   count, countAfterPop, countNext;
  logic             pop, full, accept;

  assign pop           = rxValid & rxReady;
  assign full          = (count == FullCount);
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept        = pushReq & (~full | pop);
  assign rdPtrNext     = rdPtr + AddrW'(pop);
  assign countAfterPop = count - (AddrW + 1)'(pop);
  assign countNext     = countAfterPop + (AddrW + 1)'(accept);

  always_ff @(posedge clock) begin
    if (accept) fifoMem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      rxValid    <= 1'b0;
      rxData     <= 8'h00;
      frameError <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wrPtr <= wrPtr + AddrW'(1);
      rdPtr   <= rdPtrNext;
      count   <= countNext;
      rxValid <= (countNext != '0);
      // When nothing older remains, the incoming byte becomes the head
      // directly (its RAM write lands in this same cycle).
      if (countAfterPop == '0) begin
        if (accept) rxData <= shiftReg;
      end else begin
        rxData <= fifoMem[rdPtrNext];
      end
      frameError <= frameErrSet;
      overflow   <= pushReq & full & ~pop;
    end
  end

endmodule

// File: tb/tb_oclib_uart_rx.sv
// Testbench for oclib_uart_rx at 100 cycles per bit, FifoDepth 4.
// A frame-level model (queue of bytes that must appear, with a
// deadline each) is fed by the line driver; a single compare process
// checks the byte interface and the error pulses every cycle.
`timescale 1ns/1ps
module tb_oclib_uart_rx;

  localparam int ClockHz   = 100000000;
  localparam int Baud      = 1000000;
  localparam int FifoDepth = 4;
  localparam int Bit       = 100;
`ifdef OCLIB_UART_RX_PARITY_EN
  localparam bit ParityOn  = 1'b1;
`else
  localparam bit ParityOn  = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rxReady;
  logic [7:0] rxData;
  logic       rxValid, frameError, overflow, parityError;

  oclib_uart_rx #(
    .ClockHz(ClockHz),
    .Baud(Baud),
    .FifoDepth(FifoDepth)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx(rx),
    .rxData(rxData),
    .rxValid(rxValid),
    .rxReady(rxReady),
    .frameError(frameError),
    .overflow(overflow),
    .parityError(parityError)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic doCheck(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] data;
    int         deadline;
  } entryT;

  entryT model[$];
  int expFrameErr = 0, expOverflow = 0, expParityErr = 0;
  int gotFrameErr = 0, gotOverflow = 0, gotParityErr = 0;
  int validCycles = 0;
  logic [7:0] popData[$];
  int popCyc[$];

  // What a completed frame must do: error pulse, drop, or new byte.
  task automatic recordFrame(input logic [7:0] d, input bit stopBit, input bit parBit,
                             input int deadline);
    entryT e;
    if (!stopBit) expFrameErr++;
    else if (ParityOn && (parBit != ^d)) expParityErr++;
    else if (model.size() >= FifoDepth) expOverflow++;
    else begin
      e.data     = d;
      e.deadline = deadline;
      model.push_back(e);
    end
  endtask

  // ---------------- consumer ready ----------------
  int readyMode = 0;  // 0: low, 1: high, 2: random
  always begin
    @(negedge clock);
    case (readyMode)
      0:       rxReady = 1'b0;
      1:       rxReady = 1'b1;
      default: rxReady = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- compare process ----------------
  logic prevValid = 1'b0, prevReady = 1'b0;
  logic prevFe = 1'b0, prevOv = 1'b0, prevPe = 1'b0;

  always begin
    @(negedge clock);
    #1;
    if (!reset) begin
      if (rxValid) begin
        validCycles++;
        if (model.size() == 0) begin
          doCheck(1'b0, "spurious_valid", int'(rxData), 0);
        end else begin
          doCheck(rxData == model[0].data, "rx_data", int'(rxData), int'(model[0].data));
          if (rxReady) void'(model.pop_front());
        end
        if (rxReady) begin
          popData.push_back(rxData);
          popCyc.push_back(cyc);
        end
      end else if ((model.size() != 0) && (cyc > model[0].deadline)) begin
        doCheck(1'b0, "valid_late", 0, int'(model[0].data));
        void'(model.pop_front());
      end
      if (prevValid && !prevReady) doCheck(rxValid == 1'b1, "valid_held", int'(rxValid), 1);
      if (frameError) begin
        gotFrameErr++;
        doCheck(!prevFe, "frame_error_width", 2, 1);
      end
      if (overflow) begin
        gotOverflow++;
        doCheck(!prevOv, "overflow_width", 2, 1);
      end
      if (parityError) begin
        gotParityErr++;
        doCheck(!prevPe, "parity_error_width", 2, 1);
      end
    end
    prevValid = rxValid;
    prevReady = rxReady;
    prevFe    = frameError;
    prevOv    = overflow;
    prevPe    = parityError;
  end

  // ---------------- line driver ----------------
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Nominal-rate frames are recorded at the stop-bit centre with a
  // 4-clock deadline; off-rate frames at the stop-bit start with a
  // deadline at the end of the stop bit.
  task automatic sendFrame(input logic [7:0] d, input bit stopBit, input bit parBit,
                           input int bitCyc);
    rx = 1'b0;
    repeat (bitCyc) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bitCyc) @(negedge clock);
    end
    if (ParityOn) begin
      rx = parBit;
      repeat (bitCyc) @(negedge clock);
    end
    rx = stopBit;
    if (bitCyc != Bit) recordFrame(d, stopBit, parBit, cyc + bitCyc + 4);
    repeat (bitCyc / 2) @(negedge clock);
    if (bitCyc == Bit) recordFrame(d, stopBit, parBit, cyc + 4);
    repeat (bitCyc - bitCyc / 2) @(negedge clock);
  endtask

  task automatic clearLogs();
    popData.delete();
    popCyc.delete();
    validCycles = 0;
  endtask

  task automatic phaseEnd(input string name);
    repeat (300) @(negedge clock);
    doCheck(model.size() == 0, {name, "_drained"}, model.size(), 0);
    doCheck(gotFrameErr == expFrameErr, {name, "_frame_errors"}, gotFrameErr, expFrameErr);
    doCheck(gotOverflow == expOverflow, {name, "_overflows"}, gotOverflow, expOverflow);
    doCheck(gotParityErr == expParityErr, {name, "_parity_errors"}, gotParityErr, expParityErr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 200000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int feBase, ovBase, peBase;
    logic [7:0] d;
    bit par, stopOk;
    int bc;

    // ---- reset state ----
    repeat (5) @(negedge clock);
    #2;
    doCheck(rxValid == 1'b0, "reset_rxValid", int'(rxValid), 0);
    doCheck(rxData == 8'h00, "reset_rxData", int'(rxData), 0);
    doCheck(frameError == 1'b0, "reset_frameError", int'(frameError), 0);
    doCheck(overflow == 1'b0, "reset_overflow", int'(overflow), 0);
    doCheck(parityError == 1'b0, "reset_parityError", int'(parityError), 0);
    @(negedge clock);
    reset = 1'b0;
    idle(50);

    // ---- single byte, consumer always ready ----
    readyMode = 1;
    clearLogs();
    sendFrame(8'hA5, 1'b1, ^8'hA5, Bit);
    idle(200);
    doCheck(validCycles == 1, "a5_valid_width", validCycles, 1);
    doCheck(popData.size() == 1 && popData[0] == 8'hA5, "a5_byte",
            popData.size() > 0 ? int'(popData[0]) : -1, 8'hA5);
    phaseEnd("a5");

    // ---- overflow: five bytes into a four-deep FIFO ----
    readyMode = 0;
    clearLogs();
    ovBase = gotOverflow;
    for (int i = 1; i <= 5; i++) sendFrame(8'(i), 1'b1, ^8'(i), Bit);
    idle(50);
    #2;
    doCheck(rxValid == 1'b1 && rxData == 8'h01, "ovf_head", int'(rxData), 8'h01);
    doCheck(gotOverflow - ovBase == 1, "ovf_pulses", gotOverflow - ovBase, 1);
    @(negedge clock);
    readyMode = 1;
    idle(20);
    doCheck(popData.size() == 4, "ovf_pop_count", popData.size(), 4);
    for (int i = 0; i < 4 && i < popData.size(); i++) begin
      doCheck(popData[i] == 8'(i + 1), "ovf_pop_order", int'(popData[i]), i + 1);
      if (i > 0) doCheck(popCyc[i] == popCyc[i-1] + 1, "ovf_pop_consecutive",
                         popCyc[i] - popCyc[i-1], 1);
    end
    #2;
    doCheck(rxValid == 1'b0, "ovf_empty", int'(rxValid), 0);
    phaseEnd("ovf");

    // ---- frame error, line held low (break), recovery ----
    clearLogs();
    feBase = gotFrameErr;
    sendFrame(8'h3C, 1'b0, ^8'h3C, Bit);
    rx = 1'b0;
    repeat (20 * Bit) @(negedge clock);
    idle(2 * Bit);
    sendFrame(8'h11, 1'b1, ^8'h11, Bit);
    idle(100);
    doCheck(gotFrameErr - feBase == 1, "break_frame_errors", gotFrameErr - feBase, 1);
    doCheck(popData.size() == 1 && popData[0] == 8'h11, "break_recovery_byte",
            popData.size() > 0 ? int'(popData[0]) : -1, 8'h11);
    phaseEnd("break");

    // ---- short glitch on the line ----
    clearLogs();
    feBase = gotFrameErr;
    ovBase = gotOverflow;
    rx = 1'b0;
    repeat (30) @(negedge clock);
    idle(2000);
    doCheck(validCycles == 0, "glitch_no_valid", validCycles, 0);
    doCheck(gotFrameErr == feBase && gotOverflow == ovBase, "glitch_no_errors",
            (gotFrameErr - feBase) + (gotOverflow - ovBase), 0);
    phaseEnd("glitch");

    // ---- reset in the middle of bit 3 of 0x77 ----
    clearLogs();
    rx = 1'b0;
    repeat (Bit) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;  // bits 0..2 of 0x77
      repeat (Bit) @(negedge clock);
    end
    rx = 1'b0;    // bit 3 of 0x77
    repeat (Bit / 2) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    #2;
    doCheck(rxValid == 1'b0, "midreset_rxValid", int'(rxValid), 0);
    reset = 1'b0;
    repeat (Bit / 2 - 5) @(negedge clock);
    idle(2 * Bit);
    sendFrame(8'h5A, 1'b1, ^8'h5A, Bit);
    idle(100);
    doCheck(popData.size() == 1 && popData[0] == 8'h5A, "midreset_only_5a",
            popData.size() > 0 ? int'(popData[0]) : -1, 8'h5A);
    phaseEnd("midreset");

`ifdef OCLIB_UART_RX_PARITY_EN
    // ---- parity good / bad ----
    clearLogs();
    peBase = gotParityErr;
    sendFrame(8'h07, 1'b1, 1'b1, Bit);
    idle(50);
    sendFrame(8'h07, 1'b1, 1'b0, Bit);
    idle(100);
    doCheck(popData.size() == 1 && popData[0] == 8'h07, "parity_good_only",
            popData.size(), 1);
    doCheck(gotParityErr - peBase == 1, "parity_bad_pulse", gotParityErr - peBase, 1);
    phaseEnd("parity");
`else
    peBase = gotParityErr;
`endif

    // ---- +/-3% line rate ----
    clearLogs();
    sendFrame(8'hC3, 1'b1, ^8'hC3, 97);
    idle(300);
    sendFrame(8'hC3, 1'b1, ^8'hC3, 103);
    idle(100);
    doCheck(popData.size() == 2 && popData[0] == 8'hC3 && popData[1] == 8'hC3,
            "baud_tolerance", popData.size(), 2);
    phaseEnd("baud");

    // ---- randomized traffic ----
    readyMode = 2;
    for (int n = 0; n < 16; n++) begin
      d      = 8'($urandom);
      par    = (^d) ^ ($urandom_range(0, 3) == 0);
      stopOk = ($urandom_range(0, 7) != 0);
      bc     = ($urandom_range(0, 1) == 0) ? Bit : int'($urandom_range(97, 103));
      sendFrame(d, stopOk, par, bc);
      if (!stopOk) begin
        rx = 1'b0;
        repeat (Bit) @(negedge clock);
        idle(Bit);
      end
      idle($urandom_range(0, 200));
    end
    idle(200);
    phaseEnd("random");
    if (!ParityOn) doCheck(gotParityErr == peBase, "parity_tied_low", gotParityErr, peBase);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
